wbi_buffer_loader: RTL and testbench

- Write-side loader for the W_B_I weight/bias/input buffer: accepts a valid/ready stream of 32-bit words from the DMA/host path.
- Drives BRAM port A (ena/wea/addra/dina) with generated addresses, filling one tile per start command.
- Counterpart of the port-B fetch logic: this block fills a tile, the fetch logic drains it.
- Supports double buffering: while the fetch side reads one bank, this block fills the other.

---
 rtl/wbi_pkg.sv | 15 +
 rtl/wbi_wr_addr_gen.sv | 74 +++++++
 rtl/wbi_buffer_loader.sv | 162 ++++++++++++++++
 tb/tb_wbi_buffer_loader.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wbi_pkg.sv
// Shared definitions for the W_B_I buffer loader, fetch logic and buffer top.
// Holds the loader FSM state encoding and the default port-A geometry.
package wbi_pkg;

    localparam int WBI_ADDR_WIDTH = 14;
    localparam int WBI_DATA_WIDTH = 32;
    localparam int WBI_BANK_WORDS = 8192;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } wbi_state_e;

endpackage

// File: rtl/wbi_wr_addr_gen.sv
// Port-A write address generator for the W_B_I loader: holds the word
// counter, the latched tile length and bank base, the bank select with its
// toggle/reset, and flags the last word of the tile.
module wbi_wr_addr_gen
    import wbi_pkg::*;
#(
    parameter int ADDR_WIDTH = WBI_ADDR_WIDTH,
    parameter int BANK_WORDS = WBI_BANK_WORDS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  clear,
    input  logic                  advance,
    input  logic                  toggle,
    input  logic                  reset_bank,
    input  logic [ADDR_WIDTH-1:0] load_len,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  last_word,
    output logic                  bank_sel
);

    localparam logic [ADDR_WIDTH-1:0] BANK1_BASE = ADDR_WIDTH'(BANK_WORDS);
    localparam logic [ADDR_WIDTH-1:0] ONE        = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] count_q, count_d;
    logic [ADDR_WIDTH-1:0] len_q, len_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic                  bank_sel_q, bank_sel_d;

    // Next-state for counter, length/base latch and bank select; a new tile
    // takes its base from the bank currently selected, and the DONE toggle
    // has priority over a bank reset.
    always_comb begin
        count_d    = count_q;
        len_d      = len_q;
        base_d     = base_q;
        bank_sel_d = bank_sel_q;
        if (start) begin
            count_d = '0;
            len_d   = load_len;
            base_d  = bank_sel_q ? BANK1_BASE : '0;
        end else if (clear) begin
            count_d = '0;
        end else if (advance) begin
            count_d = count_q + ONE;
        end
        if (toggle) begin
            bank_sel_d = ~bank_sel_q;
        end else if (reset_bank) begin
            bank_sel_d = 1'b0;
        end
    end

    // Address generator state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= '0;
            len_q      <= '0;
            base_q     <= '0;
            bank_sel_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            len_q      <= len_d;
            base_q     <= base_d;
            bank_sel_q <= bank_sel_d;
        end
    end

    assign wr_addr   = base_q + count_q;
    assign last_word = (count_q == (len_q - ONE));
    assign bank_sel  = bank_sel_q;

endmodule

// File: rtl/wbi_buffer_loader.sv
// Write-side loader for the W_B_I buffer: takes a valid/ready word stream
// and writes one tile per start command into BRAM port A, alternating banks
// when double buffering is enabled.
// Optional feature macro: LOAD_CHECKSUM_EN (running 32-bit sum of the tile).
module wbi_buffer_loader
    import wbi_pkg::*;
#(
    parameter int ADDR_WIDTH = WBI_ADDR_WIDTH,
    parameter int DATA_WIDTH = WBI_DATA_WIDTH,
    parameter int BANK_WORDS = WBI_BANK_WORDS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_load,
    input  logic [ADDR_WIDTH-1:0] load_len,
    input  logic                  abort,
    input  logic                  Double_buffering,
    input  logic                  reset_bank,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  ena,
    output logic                  wea,
    output logic [ADDR_WIDTH-1:0] addra,
    output logic [DATA_WIDTH-1:0] dina,
    output logic                  busy,
    output logic                  bank_sel,
    output logic                  load_done,
    output logic [31:0]           checksum
);

    wbi_state_e            state_q, state_d;
    logic                  ena_q, ena_d;
    logic                  wea_q, wea_d;
    logic [ADDR_WIDTH-1:0] addra_q, addra_d;
    logic [DATA_WIDTH-1:0] dina_q, dina_d;

    logic                  handshake;
    logic                  start_cmd;
    logic                  clear_cnt;
    logic                  bank_toggle;
    logic                  bank_reset;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  last_word;

    assign s_ready   = (state_q == LOAD) && !abort;
    assign handshake = s_valid && s_ready;

    wbi_wr_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BANK_WORDS (BANK_WORDS)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .start      (start_cmd),
        .clear      (clear_cnt),
        .advance    (handshake),
        .toggle     (bank_toggle),
        .reset_bank (bank_reset),
        .load_len   (load_len),
        .wr_addr    (wr_addr),
        .last_word  (last_word),
        .bank_sel   (bank_sel)
    );

    // FSM next state and the port-A write that follows each accepted word by
    // one cycle; a zero-length tile goes straight to DONE without writing.
    always_comb begin
        state_d     = state_q;
        ena_d       = 1'b0;
        wea_d       = 1'b0;
        addra_d     = addra_q;
        dina_d      = dina_q;
        start_cmd   = 1'b0;
        clear_cnt   = 1'b0;
        bank_toggle = 1'b0;
        bank_reset  = 1'b0;
        case (state_q)
            IDLE: begin
                bank_reset = reset_bank;
                if (start_load) begin
                    start_cmd = 1'b1;
                    state_d   = (load_len != '0) ? LOAD : DONE;
                end
            end
            LOAD: begin
                if (abort) begin
                    clear_cnt = 1'b1;
                    state_d   = IDLE;
                end else if (handshake) begin
                    ena_d   = 1'b1;
                    wea_d   = 1'b1;
                    addra_d = wr_addr;
                    dina_d  = s_data;
                    if (last_word) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                bank_toggle = Double_buffering;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and registered port-A outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ena_q   <= 1'b0;
            wea_q   <= 1'b0;
            addra_q <= '0;
            dina_q  <= '0;
        end else begin
            state_q <= state_d;
            ena_q   <= ena_d;
            wea_q   <= wea_d;
            addra_q <= addra_d;
            dina_q  <= dina_d;
        end
    end

    assign ena       = ena_q;
    assign wea       = wea_q;
    assign addra     = addra_q;
    assign dina      = dina_q;
    assign busy      = (state_q == LOAD);
    assign load_done = (state_q == DONE);

`ifdef LOAD_CHECKSUM_EN
    logic [31:0] checksum_q, checksum_d;

    // Running sum of accepted words, restarted whenever a tile enters LOAD
    // and held afterwards so it can be read alongside load_done.
    always_comb begin
        checksum_d = checksum_q;
        if ((state_q == IDLE) && start_load && (load_len != '0)) begin
            checksum_d = '0;
        end else if (handshake) begin
            checksum_d = checksum_q + 32'(s_data);
        end
    end

    // Checksum accumulator register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = 32'd0;
`endif

endmodule

// File: tb/tb_wbi_buffer_loader.sv
// Directed self-checking bench for wbi_buffer_loader.
// Checksum expectations follow LOAD_CHECKSUM_EN when it is defined.
module tb_wbi_buffer_loader;

    logic        clk;
    logic        rst;
    logic        start_load;
    logic [13:0] load_len;
    logic        abort;
    logic        Double_buffering;
    logic        reset_bank;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;
    logic        ena;
    logic        wea;
    logic [13:0] addra;
    logic [31:0] dina;
    logic        busy;
    logic        bank_sel;
    logic        load_done;
    logic [31:0] checksum;

    int total = 0;
    int bad   = 0;

    wbi_buffer_loader dut (
        .clk              (clk),
        .rst              (rst),
        .start_load       (start_load),
        .load_len         (load_len),
        .abort            (abort),
        .Double_buffering (Double_buffering),
        .reset_bank       (reset_bank),
        .s_valid          (s_valid),
        .s_data           (s_data),
        .s_ready          (s_ready),
        .ena              (ena),
        .wea              (wea),
        .addra            (addra),
        .dina             (dina),
        .busy             (busy),
        .bank_sel         (bank_sel),
        .load_done        (load_done),
        .checksum         (checksum)
    );

    // 100 MHz free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge so registered outputs have settled
    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // One comparison: counts it and reports a failure with both values
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Issue a single-cycle start_load pulse with the given length
    task automatic applyStimulus(input int len);
        start_load = 1'b1;
        load_len   = 14'(len);
        tick();
        start_load = 1'b0;
    endtask

    // Expected checksum for a given raw sum, depending on the build
    function automatic logic [31:0] expCsum(input logic [31:0] sum);
`ifdef LOAD_CHECKSUM_EN
        return sum;
`else
        return 32'd0 & sum;
`endif
    endfunction

    // Full tile with s_valid held high; words are 0x11*(i+1)
    task automatic loadTile(input int len, input int base, input string tag);
        logic [31:0] sum;
        sum = 32'd0;
        applyStimulus(len);
        checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd1);
        for (int i = 0; i < len; i++) begin
            s_valid = 1'b1;
            s_data  = 32'h11 * (i + 1);
            sum     = sum + s_data;
            tick();
            checkOutput({tag, "_ena"}, {31'd0, ena}, 32'd1);
            checkOutput({tag, "_addra"}, {18'd0, addra}, 32'(base + i));
            checkOutput({tag, "_dina"}, dina, 32'h11 * (i + 1));
            checkOutput({tag, "_done"}, {31'd0, load_done}, (i == len - 1) ? 32'd1 : 32'd0);
        end
        checkOutput({tag, "_csum"}, checksum, expCsum(sum));
        s_valid = 1'b0;
        tick();
        checkOutput({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, "_idle_done"}, {31'd0, load_done}, 32'd0);
        checkOutput({tag, "_idle_ena"}, {31'd0, ena}, 32'd0);
    endtask

    int bpValid [5] = '{1, 0, 0, 1, 1};
    int bpAddr  [5] = '{0, 0, 0, 1, 2};
    int bpDone  [5] = '{0, 0, 0, 0, 1};

    initial begin
        int donesSeen;
        rst              = 1'b1;
        start_load       = 1'b0;
        load_len         = '0;
        abort            = 1'b0;
        Double_buffering = 1'b0;
        reset_bank       = 1'b0;
        s_valid          = 1'b0;
        s_data           = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        checkOutput("rst_ena", {31'd0, ena}, 32'd0);
        checkOutput("rst_wea", {31'd0, wea}, 32'd0);
        checkOutput("rst_addra", {18'd0, addra}, 32'd0);
        checkOutput("rst_dina", dina, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, load_done}, 32'd0);
        checkOutput("rst_bank", {31'd0, bank_sel}, 32'd0);
        checkOutput("rst_sready", {31'd0, s_ready}, 32'd0);
        checkOutput("rst_csum", checksum, 32'd0);
        rst = 1'b0;
        tick();

        // Basic single-bank load of four words
        $display("[TB] basic load");
        loadTile(4, 0, "basic");
        checkOutput("basic_bank", {31'd0, bank_sel}, 32'd0);

        // Double buffering: second tile lands in bank 1
        $display("[TB] double buffering");
        Double_buffering = 1'b1;
        loadTile(3, 0, "db1");
        checkOutput("db1_bank", {31'd0, bank_sel}, 32'd1);
        loadTile(3, 8192, "db2");
        checkOutput("db2_bank", {31'd0, bank_sel}, 32'd0);
        Double_buffering = 1'b0;

        // Backpressure gaps in the stream
        $display("[TB] backpressure");
        donesSeen = 0;
        applyStimulus(3);
        for (int k = 0; k < 5; k++) begin
            s_valid = bpValid[k][0];
            s_data  = 32'hA0 + k;
            tick();
            checkOutput("bp_ena", {31'd0, ena}, 32'(bpValid[k]));
            checkOutput("bp_wea", {31'd0, wea}, 32'(bpValid[k]));
            checkOutput("bp_addra", {18'd0, addra}, 32'(bpAddr[k]));
            checkOutput("bp_done", {31'd0, load_done}, 32'(bpDone[k]));
            if (load_done) donesSeen++;
        end
        s_valid = 1'b0;
        tick();
        if (load_done) donesSeen++;
        checkOutput("bp_done_count", 32'(donesSeen), 32'd1);

        // Abort after three accepted words
        $display("[TB] abort");
        applyStimulus(8);
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1;
            s_data  = 32'h100 + i;
            tick();
            checkOutput("ab_addra", {18'd0, addra}, 32'(i));
        end
        abort  = 1'b1;
        s_data = 32'hDEAD;
        #1;
        checkOutput("ab_sready", {31'd0, s_ready}, 32'd0);
        tick();
        checkOutput("ab_ena", {31'd0, ena}, 32'd0);
        checkOutput("ab_busy", {31'd0, busy}, 32'd0);
        checkOutput("ab_done", {31'd0, load_done}, 32'd0);
        checkOutput("ab_bank", {31'd0, bank_sel}, 32'd0);
        abort   = 1'b0;
        s_valid = 1'b0;
        tick();
        checkOutput("ab_late_done", {31'd0, load_done}, 32'd0);
        loadTile(2, 0, "restart");

        // Zero-length tile
        $display("[TB] zero length");
        applyStimulus(0);
        checkOutput("z_done", {31'd0, load_done}, 32'd1);
        checkOutput("z_ena", {31'd0, ena}, 32'd0);
        checkOutput("z_busy", {31'd0, busy}, 32'd0);
        tick();
        checkOutput("z_done_end", {31'd0, load_done}, 32'd0);

        // start_load while loading is ignored
        $display("[TB] start during load");
        applyStimulus(4);
        for (int i = 0; i < 4; i++) begin
            s_valid    = 1'b1;
            s_data     = 32'h200 + i;
            start_load = (i == 1);
            load_len   = 14'd2;
            tick();
            checkOutput("sl_addra", {18'd0, addra}, 32'(i));
            checkOutput("sl_done", {31'd0, load_done}, (i == 3) ? 32'd1 : 32'd0);
        end
        start_load = 1'b0;
        s_valid    = 1'b0;
        tick();
        checkOutput("sl_busy", {31'd0, busy}, 32'd0);

        // reset_bank in IDLE
        $display("[TB] reset_bank");
        Double_buffering = 1'b1;
        loadTile(1, 0, "rb");
        checkOutput("rb_bank1", {31'd0, bank_sel}, 32'd1);
        reset_bank = 1'b1;
        tick();
        reset_bank = 1'b0;
        checkOutput("rb_bank0", {31'd0, bank_sel}, 32'd0);
        Double_buffering = 1'b0;

        // Checksum wraps modulo 2^32
        $display("[TB] checksum");
        applyStimulus(2);
        s_valid = 1'b1;
        s_data  = 32'hFFFF_FFFF;
        tick();
        s_data  = 32'h2;
        tick();
        checkOutput("cs_done", {31'd0, load_done}, 32'd1);
        checkOutput("cs_value", checksum, expCsum(32'h1));
        s_valid = 1'b0;
        tick();
        checkOutput("cs_hold", checksum, expCsum(32'h1));

        // Asynchronous reset in the middle of a bank-1 load
        $display("[TB] reset mid-load");
        Double_buffering = 1'b1;
        loadTile(1, 0, "pre");
        applyStimulus(4);
        s_valid = 1'b1;
        s_data  = 32'h55;
        tick();
        checkOutput("mr_addra", {18'd0, addra}, 32'd8192);
        rst = 1'b1;
        #1;
        checkOutput("mr_ena", {31'd0, ena}, 32'd0);
        checkOutput("mr_wea", {31'd0, wea}, 32'd0);
        checkOutput("mr_addra0", {18'd0, addra}, 32'd0);
        checkOutput("mr_dina", dina, 32'd0);
        checkOutput("mr_busy", {31'd0, busy}, 32'd0);
        checkOutput("mr_sready", {31'd0, s_ready}, 32'd0);
        checkOutput("mr_bank", {31'd0, bank_sel}, 32'd0);
        checkOutput("mr_done", {31'd0, load_done}, 32'd0);
        s_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        checkOutput("mr_after_busy", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
